// File: rtl/cdic_sector_receiver.sv
// CDIC sector receiver: seek/tick control and double-banked sector assembly
// with sync and length checking and header capture.
module cdic_sector_receiver #(
    parameter int TICK_DIV     = 400000,
    parameter int SECTOR_WORDS = 1188
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_seek,
    input  logic [31:0] cmd_lba,
    input  logic        cmd_stop,
    input  logic        double_speed,
    output logic [31:0] seek_lba,
    output logic        seek_lba_valid,
    output logic        sector_tick,
    input  logic [15:0] cd_data,
    input  logic        cd_data_valid,
    input  logic        sector_delivered,
    output logic        buf_wr_en,
    output logic [11:0] buf_wr_addr,
    output logic [15:0] buf_wr_data,
    output logic        sector_done,
    output logic        sector_error,
    output logic        done_bank,
    output logic [23:0] header_msf,
    output logic [7:0]  header_mode,
    output logic        missed_sector
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LIM_S = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] LIM_D = CW'(TICK_DIV / 2 - 1);
    localparam logic [10:0] SW = 11'(SECTOR_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RECV, FINISH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ds_q, ds_d;
    logic [10:0]   idx_q, idx_d;
    logic          bank_q, bank_d;
    logic          stream_q, stream_d;
    logic          sync_f_q, sync_f_d;
    logic          len_f_q, len_f_d;
    logic [15:0]   ms_q, ms_d;
    logic [15:0]   fm_q, fm_d;
    logic [31:0]   seek_lba_q, seek_lba_d;
    logic          seek_v_q, seek_v_d;
    logic          tick_q, tick_d;
    logic          wr_en_q, wr_en_d;
    logic [11:0]   wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          done_bank_q, done_bank_d;
    logic [23:0]   msf_q, msf_d;
    logic [7:0]    mode_q, mode_d;
    logic          missed_q, missed_d;
    logic          sync_bad;
    logic [CW-1:0] lim;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ds_d        = ds_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        stream_d    = stream_q;
        sync_f_d    = sync_f_q;
        len_f_d     = len_f_q;
        ms_d        = ms_q;
        fm_d        = fm_q;
        seek_lba_d  = seek_lba_q;
        seek_v_d    = 1'b0;
        tick_d      = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        done_bank_d = done_bank_q;
        msf_d       = msf_q;
        mode_d      = mode_q;
        missed_d    = 1'b0;
        lim         = ds_q ? LIM_D : LIM_S;

        // Sync pattern occupies words 0..5, high byte first.
        sync_bad = 1'b0;
        if (idx_q == 11'd0) begin
            sync_bad = (cd_data != 16'h00FF);
        end else if (idx_q <= 11'd4) begin
            sync_bad = (cd_data != 16'hFFFF);
        end else if (idx_q == 11'd5) begin
            sync_bad = (cd_data != 16'hFF00);
        end

        if (state_q != IDLE) begin
            if (cnt_q == lim) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                ds_d   = double_speed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        missed_d = tick_d && (state_q == WAIT) && stream_q;

        if (cmd_seek) begin
            seek_lba_d = cmd_lba;
            seek_v_d   = 1'b1;
            cnt_d      = '0;
            tick_d     = 1'b0;
            missed_d   = 1'b0;
            ds_d       = double_speed;
            stream_d   = 1'b0;
            idx_d      = '0;
            sync_f_d   = 1'b0;
            len_f_d    = 1'b0;
            state_d    = WAIT;
        end else if (cmd_stop) begin
            cnt_d    = '0;
            tick_d   = 1'b0;
            missed_d = 1'b0;
            idx_d    = '0;
            sync_f_d = 1'b0;
            len_f_d  = 1'b0;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: ;
                WAIT, RECV: begin
                    if (cd_data_valid) begin
                        state_d = RECV;
                        if (idx_q < SW) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = {bank_q, idx_q};
                            wr_data_d = cd_data;
                            idx_d     = idx_q + 1'b1;
                            if (sync_bad) sync_f_d = 1'b1;
                            if (idx_q == 11'd6) ms_d = cd_data;
                            if (idx_q == 11'd7) fm_d = cd_data;
                        end else begin
                            len_f_d = 1'b1;
                        end
                    end
                    if (sector_delivered) state_d = FINISH;
                end
                FINISH: begin
                    done_d      = 1'b1;
                    err_d       = sync_f_q | len_f_q | (idx_q != SW);
                    done_bank_d = bank_q;
                    msf_d       = {ms_q, fm_q[15:8]};
                    mode_d      = fm_q[7:0];
                    bank_d      = ~bank_q;
                    stream_d    = 1'b1;
                    sync_f_d    = 1'b0;
                    len_f_d     = 1'b0;
                    idx_d       = '0;
                    state_d     = WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ds_q        <= 1'b0;
            idx_q       <= '0;
            bank_q      <= 1'b0;
            stream_q    <= 1'b0;
            sync_f_q    <= 1'b0;
            len_f_q     <= 1'b0;
            ms_q        <= '0;
            fm_q        <= '0;
            seek_lba_q  <= '0;
            seek_v_q    <= 1'b0;
            tick_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            done_bank_q <= 1'b0;
            msf_q       <= '0;
            mode_q      <= '0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ds_q        <= ds_d;
            idx_q       <= idx_d;
            bank_q      <= bank_d;
            stream_q    <= stream_d;
            sync_f_q    <= sync_f_d;
            len_f_q     <= len_f_d;
            ms_q        <= ms_d;
            fm_q        <= fm_d;
            seek_lba_q  <= seek_lba_d;
            seek_v_q    <= seek_v_d;
            tick_q      <= tick_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            done_bank_q <= done_bank_d;
            msf_q       <= msf_d;
            mode_q      <= mode_d;
            missed_q    <= missed_d;
        end
    end

    assign seek_lba       = seek_lba_q;
    assign seek_lba_valid = seek_v_q;
    assign sector_tick    = tick_q;
    assign buf_wr_en      = wr_en_q;
    assign buf_wr_addr    = wr_addr_q;
    assign buf_wr_data    = wr_data_q;
    assign sector_done    = done_q;
    assign sector_error   = err_q;
    assign done_bank      = done_bank_q;
    assign header_msf     = msf_q;
    assign header_mode    = mode_q;
    assign missed_sector  = missed_q;
endmodule

// File: tb/tb_cdic_sector_receiver.sv
// Scoreboard bench for cdic_sector_receiver: expected writes, seeks and
// sector completions are queued by stimulus and checked by a monitor.
module tb_cdic_sector_receiver;
    localparam int P  = 6000;
    localparam int SW = 1188;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_seek = 1'b0;
    logic [31:0] cmd_lba = '0;
    logic        cmd_stop = 1'b0;
    logic        double_speed = 1'b0;
    logic [31:0] seek_lba;
    logic        seek_lba_valid;
    logic        sector_tick;
    logic [15:0] cd_data = '0;
    logic        cd_data_valid = 1'b0;
    logic        sector_delivered = 1'b0;
    logic        buf_wr_en;
    logic [11:0] buf_wr_addr;
    logic [15:0] buf_wr_data;
    logic        sector_done;
    logic        sector_error;
    logic        done_bank;
    logic [23:0] header_msf;
    logic [7:0]  header_mode;
    logic        missed_sector;

    cdic_sector_receiver #(.TICK_DIV(P), .SECTOR_WORDS(SW)) dut (
        .clk(clk), .reset(reset),
        .cmd_seek(cmd_seek), .cmd_lba(cmd_lba),
        .cmd_stop(cmd_stop), .double_speed(double_speed),
        .seek_lba(seek_lba), .seek_lba_valid(seek_lba_valid),
        .sector_tick(sector_tick),
        .cd_data(cd_data), .cd_data_valid(cd_data_valid),
        .sector_delivered(sector_delivered),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data),
        .sector_done(sector_done), .sector_error(sector_error),
        .done_bank(done_bank), .header_msf(header_msf),
        .header_mode(header_mode), .missed_sector(missed_sector)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tick_cnt = 0;
    int last_tick = 0;
    int seek_cyc = 0;
    int missed_cnt = 0;
    int done_seen = 0;
    int done_pushed = 0;
    logic exp_bank = 1'b0;

    logic [27:0] wq[$];
    logic [33:0] dq[$];
    logic [31:0] sq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (buf_wr_en) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected got=%h/%h",
                             buf_wr_addr, buf_wr_data);
                end else begin
                    logic [27:0] e;
                    e = wq.pop_front();
                    if ({buf_wr_addr, buf_wr_data} !== e) begin
                        errors++;
                        $display("FAIL wr got=%h/%h exp=%h/%h",
                                 buf_wr_addr, buf_wr_data,
                                 e[27:16], e[15:0]);
                    end
                end
            end
            if (sector_done) begin
                done_seen++;
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected bank=%0d", done_bank);
                end else begin
                    logic [33:0] e;
                    e = dq.pop_front();
                    if ({sector_error, done_bank, header_msf,
                         header_mode} !== e) begin
                        errors++;
                        $display("FAIL done got=%b/%b/%h/%h exp=%b/%b/%h/%h",
                                 sector_error, done_bank, header_msf,
                                 header_mode, e[33], e[32], e[31:8], e[7:0]);
                    end
                end
            end
            if (seek_lba_valid) begin
                seek_cyc = cyc;
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL seek_unexpected got=%h", seek_lba);
                end else begin
                    logic [31:0] e;
                    e = sq.pop_front();
                    if (seek_lba !== e) begin
                        errors++;
                        $display("FAIL seek got=%h exp=%h", seek_lba, e);
                    end
                end
            end
            if (sector_tick) begin
                tick_cnt++;
                last_tick = cyc;
            end
            if (missed_sector) missed_cnt++;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic do_seek(input logic [31:0] lba);
        @(posedge clk); #1;
        cmd_seek = 1'b1;
        cmd_lba  = lba;
        sq.push_back(lba);
        @(posedge clk); #1;
        cmd_seek = 1'b0;
    endtask

    task automatic wait_ticks(input int n, input int budget, output bit ok);
        int start;
        start = tick_cnt;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (tick_cnt >= start + n) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic send_sector(input int n, input bit bad3,
                               input logic [15:0] ms, input logic [15:0] fm,
                               input logic [15:0] seed, input bit coincide,
                               input bit deliver);
        logic [15:0] w;
        bit err;
        err = bad3 || (n != SW);
        for (int i = 0; i < n; i++) begin
            if (i == 0) w = 16'h00FF;
            else if (i == 3 && bad3) w = 16'hFFFE;
            else if (i <= 4) w = 16'hFFFF;
            else if (i == 5) w = 16'hFF00;
            else if (i == 6) w = ms;
            else if (i == 7) w = fm;
            else w = 16'(i * 7) ^ seed;
            if (i < SW) wq.push_back({exp_bank, 11'(i), w});
            if (deliver && coincide && i == n - 1) begin
                dq.push_back({err, exp_bank, ms, fm});
                done_pushed++;
                exp_bank = ~exp_bank;
            end
            @(posedge clk); #1;
            cd_data_valid = 1'b1;
            cd_data = w;
            if (deliver && coincide && i == n - 1) sector_delivered = 1'b1;
            @(posedge clk); #1;
            cd_data_valid = 1'b0;
            sector_delivered = 1'b0;
            repeat (2) @(posedge clk);
        end
        if (deliver && !coincide) begin
            dq.push_back({err, exp_bank, ms, fm});
            done_pushed++;
            exp_bank = ~exp_bank;
            @(posedge clk); #1;
            sector_delivered = 1'b1;
            @(posedge clk); #1;
            sector_delivered = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int t2, ms0, ts0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              int'({seek_lba_valid, sector_tick, buf_wr_en, sector_done,
                    sector_error, done_bank, missed_sector}) +
              int'(seek_lba != 0) + int'(buf_wr_addr != 0) +
              int'(buf_wr_data != 0) + int'(header_msf != 0) +
              int'(header_mode != 0), 0);
        reset = 1'b0;

        do_seek(32'h0000_1234);
        wait_ticks(1, P + 100, ok);
        check("first_tick_seen", int'(ok), 1);
        check("first_tick_delay", last_tick - seek_cyc, P);
        double_speed = 1'b1;
        wait_ticks(1, P + 100, ok);
        t2 = last_tick;
        wait_ticks(1, P + 100, ok);
        check("ds_tick_seen", int'(ok), 1);
        check("ds_tick_period", last_tick - t2, P / 2);
        double_speed = 1'b0;

        // Two clean sectors back to back; the second ends with a word
        // coinciding with sector_delivered.
        do_seek(32'h10);
        send_sector(SW, 1'b0, 16'h0002, 16'h1002, 16'h5A5A, 1'b0, 1'b1);
        send_sector(SW, 1'b0, 16'h0003, 16'h2001, 16'hA5A5, 1'b1, 1'b1);

        do_seek(32'h20);
        send_sector(SW, 1'b1, 16'h0104, 16'h0502, 16'h1111, 1'b0, 1'b1);
        send_sector(1000, 1'b0, 16'h0105, 16'h0602, 16'h2222, 1'b0, 1'b1);

        do_seek(32'h30);
        send_sector(SW + 2, 1'b0, 16'h0206, 16'h0701, 16'h3333, 1'b0, 1'b1);

        ms0 = missed_cnt;
        wait_ticks(2, 2 * P + 200, ok);
        repeat (2) @(posedge clk);
        check("missed_two_ticks", missed_cnt - ms0, 2);

        do_seek(32'h40);
        send_sector(500, 1'b0, 16'h0307, 16'h0802, 16'h4444, 1'b0, 1'b0);
        do_seek(32'h41);
        send_sector(SW, 1'b0, 16'h0308, 16'h0902, 16'h5555, 1'b0, 1'b1);

        @(posedge clk); #1;
        cmd_stop = 1'b1;
        @(posedge clk); #1;
        cmd_stop = 1'b0;
        ts0 = tick_cnt;
        repeat (P + 50) @(posedge clk);
        check("no_tick_after_stop", tick_cnt - ts0, 0);
        @(posedge clk); #1;
        sector_delivered = 1'b1;
        @(posedge clk); #1;
        sector_delivered = 1'b0;
        repeat (5) @(posedge clk);

        check("done_count", done_seen, done_pushed);
        check("missed_total", missed_cnt, 2);
        check("wq_empty", wq.size(), 0);
        check("dq_empty", dq.size(), 0);
        check("sq_empty", sq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdic_sector_receiver.md
Name: cdic_sector_receiver

Overview:
CDIC-side consumer of the sector cache word stream. Issues seek requests and generates the 75/150 Hz sector_tick. Assembles each delivered sector word-by-word into a double-banked sector buffer. Checks sync and extracts the header, then signals per-sector completion and errors to the CDIC register/IRQ logic.

Parameters:
TICK_DIV, 400000, clocks per sector at single speed (30 MHz / 75)
SECTOR_WORDS, 1188, words per delivered sector (1176 data + 12 subchannel)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cmd_seek  input  1  pulse: seek to cmd_lba and start reading
cmd_lba  input  32  target LBA, sampled with cmd_seek
cmd_stop  input  1  pulse: stop reading
double_speed  input  1  1 = tick period TICK_DIV/2
seek_lba  output  32  LBA to sector cache
seek_lba_valid  output  1  one-cycle seek pulse to sector cache
sector_tick  output  1  one-cycle sector timing pulse
cd_data  input  16  word from sector cache
cd_data_valid  input  1  word strobe (at most one per 4 clocks)
sector_delivered  input  1  pulse: cache finished current sector
buf_wr_en  output  1  sector buffer write strobe
buf_wr_addr  output  12  {bank, word index[10:0]}
buf_wr_data  output  16  word to write
sector_done  output  1  pulse: sector complete in bank
sector_error  output  1  qualifies sector_done: sync or length fault
done_bank  output  1  bank that sector_done refers to
header_msf  output  24  {min, sec, frame} bytes of last completed sector
header_mode  output  8  mode byte of last completed sector
missed_sector  output  1  pulse: tick passed with no data after streaming began

Behaviour:
- Reset values: all outputs 0; state IDLE; bank 0; tick counter 0; streaming flag 0.
- States: IDLE, WAIT, RECV, FINISH.
- cmd_seek, in any state: next cycle seek_lba=cmd_lba and seek_lba_valid=1 for one cycle. Tick counter cleared. Bank unchanged. Streaming flag cleared. State goes to WAIT. A partial sector is abandoned without sector_done.
- cmd_stop, in any state: goes to IDLE with no sector_done. cmd_seek wins if both are asserted in the same cycle.
- Tick generation: runs only when not IDLE.
  - Counter counts 0..P-1, where P = TICK_DIV, or TICK_DIV/2 when double_speed=1.
  - sector_tick pulses on the wrap, so the first tick comes P clocks after seek.
  - double_speed is sampled at each wrap.
- WAIT:
  - First cd_data_valid moves the state to RECV, with word index 0.
  - Each sector_tick seen in WAIT while the streaming flag is 1 pulses missed_sector.
- RECV, per valid word (latency 1):
  - buf_wr_en=1, buf_wr_addr={bank, index}, buf_wr_data=cd_data. Index then increments.
  - Sync check, high byte = first byte: word0=16'h00FF, words 1..4=16'hFFFF, word5=16'hFF00. Any mismatch latches a sync fault.
  - Word6 = {min, sec}, word7 = {frame, mode}. These are held internally and published only at sector_done.
  - Words beyond SECTOR_WORDS-1 are not written and latch a length fault.
- sector_delivered (RECV or WAIT) moves the state to FINISH. FINISH lasts one cycle, then the state goes to WAIT.
  - sector_done=1 and done_bank=bank.
  - sector_error = sync fault | length fault | (index != SECTOR_WORDS).
  - header_msf/header_mode updated.
  - Bank toggles, the streaming flag is set, and the faults are cleared.
- A sector_delivered that coincides with the final cd_data_valid counts that word before FINISH.
- sector_delivered in IDLE is ignored.
- Reset mid-sector: everything returns to reset values immediately (async), with no pulses emitted.

Test Plan:
- Reset, then cmd_seek with cmd_lba=0x1234 → seek_lba_valid for 1 cycle with seek_lba=0x1234, and the first sector_tick exactly 400000 clocks later. With double_speed=1, ticks every 200000 clocks.
- Deliver 1188 words with a correct sync pattern, word6=0x0002, word7=0x1002, then sector_delivered → 1188 writes to addr 0x000..0x4A3, sector_done=1, sector_error=0, done_bank=0, header_msf=0x000210, header_mode=0x02.
- Second clean sector → writes to 0x800..0xCA3, done_bank=1.
- Word3=0xFFFE → sector_done with sector_error=1, while the bank still toggles. A short sector of 1000 words followed by sector_delivered → sector_error=1.
- After one completed sector, withhold data for 2 ticks → exactly 2 missed_sector pulses.
- cmd_seek at word 500 of a sector → no sector_done. The next full sector writes from index 0 in the same bank, with done_bank unchanged.
- cmd_stop → sector_tick ceases. A later sector_delivered produces no sector_done.
